// File: rtl/mem_init_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_init_pkg : shared FSM encoding and sizing helpers for mem_init_loader
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mem_init_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

  // A one-byte word still needs a 1-bit lane counter to keep widths legal.
  function automatic int byte_cnt_width(input int data_width);
    int bpw;
    bpw = data_width / BYTE_WIDTH;
    return (bpw <= 1) ? 1 : $clog2(bpw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_init_loader_if.sv
// -----------------------------------------------------------------------------
// mem_init_loader_if : boot byte stream plus memory-mux init port
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface mem_init_loader_if
  import mem_init_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);

  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_ready;

  logic                  wr_enable_init;
  logic [ADDR_WIDTH-1:0] waddr_init;
  logic [DATA_WIDTH-1:0] mem_data_in_init;
  logic                  rd_enable_init;
  logic [ADDR_WIDTH-1:0] raddr_init;
  logic [DATA_WIDTH-1:0] mem_data_out_init;

  modport master (
    input  in_valid, in_data, mem_data_out_init,
    output in_ready, wr_enable_init, waddr_init, mem_data_in_init,
           rd_enable_init, raddr_init
  );

  modport slave (
    output in_valid, in_data, mem_data_out_init,
    input  in_ready, wr_enable_init, waddr_init, mem_data_in_init,
           rd_enable_init, raddr_init
  );

endinterface

`default_nettype wire

// File: rtl/mem_init_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer : little-endian byte-to-word assembler with last-lane strobe
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module byte_packer
  import mem_init_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  clear,
  input  wire logic                  accept,
  input  wire logic [BYTE_WIDTH-1:0] data,
  output logic      [DATA_WIDTH-1:0] word,
  output logic                       word_valid
);

  localparam int            BPW       = bytes_per_word(DATA_WIDTH);
  localparam int            CW        = byte_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_LANE = CW'(BPW - 1);

  logic [CW-1:0]         byte_cnt;
  logic [DATA_WIDTH-1:0] word_r;

  // word already contains the byte being accepted, so the FSM can register
  // the complete word on the same edge that takes the last byte.
  always_comb begin
    word = word_r;
    if (accept) begin
      word[byte_cnt*BYTE_WIDTH +: BYTE_WIDTH] = data;
    end
  end

  assign word_valid = accept && (byte_cnt == LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word_r   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_r   <= '0;
    end else if (accept) begin
      word_r   <= word;
      byte_cnt <= word_valid ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_init_loader.sv
// -----------------------------------------------------------------------------
// mem_init_loader : boot-time memory fill sequencer; optional read-back
// checksum verify under MEM_INIT_VERIFY_EN.   Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_init_loader
  import mem_init_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int WORD_COUNT = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          start,
  mem_init_loader_if.master  bus,
  output logic               sel,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  in_ready_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  accept;
  logic                  clear;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

`ifdef MEM_INIT_VERIFY_EN
  logic [DATA_WIDTH-1:0] checksum;
  logic [DATA_WIDTH-1:0] read_xor;
  logic                  rd_en_r;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  error_r;
`endif

  assign accept = bus.in_valid && in_ready_r;
  assign clear  = (state == ST_IDLE) && start;

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .data       (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      waddr_r    <= '0;
      wdata_r    <= '0;
      sel        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
      checksum   <= '0;
      read_xor   <= '0;
      rd_en_r    <= 1'b0;
      raddr_r    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      error_r    <= 1'b0;
`endif
    end else begin
      wr_en_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            word_addr  <= '0;
            in_ready_r <= 1'b1;
            sel        <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef MEM_INIT_VERIFY_EN
            checksum   <= '0;
            error_r    <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            state      <= ST_WRITE;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b1;
            waddr_r    <= word_addr;
            wdata_r    <= word;
`ifdef MEM_INIT_VERIFY_EN
            checksum   <= checksum ^ word;
`endif
          end
        end
        ST_WRITE: begin
          if (word_addr == LAST_ADDR) begin
`ifdef MEM_INIT_VERIFY_EN
            state      <= ST_VERIFY;
            rd_en_r    <= 1'b1;
            raddr_r    <= '0;
            read_xor   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
`else
            state      <= ST_FINISH;
`endif
          end else begin
            state      <= ST_LOAD;
            word_addr  <= word_addr + 1'b1;
            in_ready_r <= 1'b1;
          end
        end
`ifdef MEM_INIT_VERIFY_EN
        // Read data trails rd_en_r by one cycle; rd_last_q marks the final word.
        ST_VERIFY: begin
          rd_valid_q <= rd_en_r;
          rd_last_q  <= rd_en_r && (raddr_r == LAST_ADDR);
          if (rd_en_r) begin
            if (raddr_r == LAST_ADDR) begin
              rd_en_r <= 1'b0;
            end else begin
              raddr_r <= raddr_r + 1'b1;
            end
          end
          if (rd_valid_q) begin
            read_xor <= read_xor ^ bus.mem_data_out_init;
          end
          if (rd_last_q) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if ((read_xor ^ bus.mem_data_out_init) == checksum) begin
              sel <= 1'b1;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
`endif
        ST_FINISH: begin
          state <= ST_IDLE;
          sel   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready         = in_ready_r;
  assign bus.wr_enable_init   = wr_en_r;
  assign bus.waddr_init       = waddr_r;
  assign bus.mem_data_in_init = wdata_r;

`ifdef MEM_INIT_VERIFY_EN
  assign bus.rd_enable_init = rd_en_r;
  assign bus.raddr_init     = raddr_r;
  assign error              = error_r;
`else
  logic unused_rdata;
  assign unused_rdata       = ^bus.mem_data_out_init;
  assign bus.rd_enable_init = 1'b0;
  assign bus.raddr_init     = '0;
  assign error              = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Boot-time sequencer that owns the init side of the memory port mux and fills the memory from a byte stream.
- Assembles bytes into DATA_WIDTH words and writes them sequentially from address 0 to WORD_COUNT-1.
- On completion, drives sel high to hand the memory to the user side.
- Sits between the boot byte source (UART/SPI receiver) and the mux init port; sel is this block's output.

Parameters:
- DATA_WIDTH, 32: memory word width; must be a multiple of 8.
- ADDR_WIDTH, 6: word address width, equal to the mux init address width.
- WORD_COUNT, 64: number of words loaded per start; 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock; top level also ties wclk_init/rclk_init to clk.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- wr_enable_init  out  1  init write enable.
- waddr_init  out  ADDR_WIDTH  init write address.
- mem_data_in_init  out  DATA_WIDTH  init write data.
- rd_enable_init  out  1  init read enable (verify only).
- raddr_init  out  ADDR_WIDTH  init read address.
- mem_data_out_init  in  DATA_WIDTH  init read data, valid 1 cycle after rd_enable_init.
- sel  out  1  0 = init owns memory, 1 = user owns memory.
- busy  out  1  load in progress.
- done  out  1  level; load complete.
- error  out  1  level; verify mismatch (held 0 without verify).

Behaviour:
- Reset (async) values:
  - Outputs: all 0, so sel=0 and the init side owns memory.
  - Internal state: state=IDLE, byte_cnt=0, word_addr=0.
- FSM states:
  - IDLE: in_ready=0; on start -> LOAD, busy=1, done=0, error=0, sel=0.
  - LOAD: in_ready=1.
    - Each accepted byte goes into byte lane byte_cnt, little-endian (first byte -> bits [7:0]).
    - byte_cnt increments per accepted byte.
    - When the last byte of a word is accepted, the word is registered and the FSM -> WRITE.
  - WRITE: exactly one cycle.
    - wr_enable_init=1, waddr_init=word_addr, mem_data_in_init=assembled word; in_ready=0.
    - If word_addr==WORD_COUNT-1 -> FINISH (or VERIFY when MEM_INIT_VERIFY_EN); else word_addr+1 and -> LOAD.
  - FINISH: one cycle, then -> IDLE with sel=1, done=1, busy=0.
- Latency: a word is written on the cycle after its last byte is accepted. Best-case throughput is BYTES_PER_WORD+1 cycles per word.
- in_valid gaps stall LOAD indefinitely; there is no timeout.
- start while busy is ignored.
- start while done (sel=1) restarts the load:
  - sel drops to 0 on the cycle after start.
  - done clears; word_addr and byte_cnt reset to 0.
- Only 0..WORD_COUNT-1 are ever written. Addresses never wrap; bytes after the final word are not accepted (in_ready=0 outside LOAD).
- Outputs are registered; wr_enable_init is never asserted when sel=1.
- rst mid-load aborts immediately: sel=0, memory contents partial, done=0.

Optional Feature:
- Macro: MEM_INIT_VERIFY_EN.
- With the macro:
  - A DATA_WIDTH XOR checksum accumulates over written words.
  - After the last WRITE, state VERIFY reads addresses 0..WORD_COUNT-1: one rd_enable_init per cycle, compare data XORed one cycle later.
  - On completion:
    - Checksum mismatch -> error=1, done=1, sel stays 0.
    - Match -> sel=1, done=1.
- Without the macro: no VERIFY state; rd_enable_init and raddr_init are tied 0, and error is tied 0.

Decomposition:
- Shared package mem_init_pkg:
  - FSM state encoding (IDLE, LOAD, WRITE, VERIFY, FINISH).
  - BYTES_PER_WORD = DATA_WIDTH/8.
  - Byte-counter width = clog2(BYTES_PER_WORD), minimum 1.
- Sub-module byte_packer (byte_cnt plus shift/lane insert, emits word_valid).
- The FSM and address counter stay in mem_init_loader.

Test Plan:
- Reset then idle 10 cycles -> sel=0, in_ready=0, no wr_enable_init.
- DATA_WIDTH=32, WORD_COUNT=4; start, then stream bytes 0x00..0x0F back-to-back -> writes addr0=0x03020100 … addr3=0x0F0E0D0C, one wr pulse each, then sel=1, done=1.
- Same stream with in_valid deasserted randomly 50% -> identical memory image and write order.
- Assert rst after 6 bytes -> sel=0, busy=0, no further writes.
- Start again after done -> sel falls to 0 the next cycle and the reload overwrites from addr 0.
- MEM_INIT_VERIFY_EN, memory model corrupts addr2 bit 0 -> error=1, done=1, sel=0. Clean model -> sel=1, error=0.
